// File: rtl/riscv_isa_pkg.sv
// riscv_isa_pkg: RV32I format tags, opcodes and immediate range limits shared by the encoder and its bench
package riscv_isa_pkg;
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] OP     = 7'h33;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;
endpackage

// File: rtl/imm_packer.sv
// imm_packer: (fmt, imm) -> immediate bits scattered into instruction positions plus range/illegal-format error
module imm_packer
  import riscv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] mask,
  output logic        err
);
  logic signed [31:0] s;
  assign s = $signed(imm);
  always_comb begin
    mask = 32'h0;
    err  = 1'b0;
    case (fmt)
      FMT_R: err = 1'b0;
      FMT_I: begin
        mask = {imm[11:0], 20'h0};
        err  = s < IMM12_MIN || s > IMM12_MAX;
      end
      FMT_S: begin
        mask = {imm[11:5], 13'h0, imm[4:0], 7'h0};
        err  = s < IMM12_MIN || s > IMM12_MAX;
      end
      FMT_B: begin
        mask = {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0};
        err  = s < IMM13_MIN || s > IMM13_MAX || imm[0];
      end
      FMT_U: begin
        mask = {imm[31:12], 12'h0};
        err  = imm[11:0] != 12'h0;
      end
      FMT_J: begin
        mask = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0};
        err  = s < IMM21_MIN || s > IMM21_MAX || imm[0];
      end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: registered RV32I encoder; in_* request fields -> out_word/out_err/out_addr with valid/ready on both sides
module instr_encoder
  import riscv_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        err_sticky
);
  logic [31:0] imm_mask, enc_word, word_d, word_q, addr_d, addr_q;
  logic imm_err, legal, use_rd, use_rs1, use_rs2, use_f3, use_f7, accept, handshake;
  logic valid_d, valid_q, err_d, err_q, sticky_d, sticky_q;
  imm_packer u_imm_packer (
    .fmt  (in_fmt),
    .imm  (in_imm),
    .mask (imm_mask),
    .err  (imm_err)
  );
  always_comb begin
    legal     = in_fmt <= FMT_J;
    use_rd    = in_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
    use_rs1   = in_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    use_rs2   = in_fmt inside {FMT_R, FMT_S, FMT_B};
    use_f3    = use_rs1;
    use_f7    = in_fmt == FMT_R;
    enc_word  = legal ? imm_mask | {use_f7 ? in_funct7 : 7'h0, use_rs2 ? in_rs2 : 5'h0,
                                    use_rs1 ? in_rs1 : 5'h0, use_f3 ? in_funct3 : 3'h0,
                                    use_rd ? in_rd : 5'h0, in_opcode} : 32'h0;
    in_ready  = !valid_q || out_ready;
    accept    = in_valid && in_ready;
    handshake = valid_q && out_ready;
    valid_d   = accept || (valid_q && !out_ready);
    word_d    = accept ? enc_word : word_q;
    err_d     = accept ? imm_err : err_q;
    sticky_d  = sticky_q || (accept && imm_err);
    addr_d    = handshake ? addr_q + 32'd4 : addr_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      word_q   <= 32'h0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      addr_q   <= BASE_ADDR;
    end else begin
      valid_q  <= valid_d;
      word_q   <= word_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      addr_q   <= addr_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_word   = word_q;
  assign out_err    = err_q;
  assign out_addr   = addr_q;
  assign err_sticky = sticky_q;
endmodule
